// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared definitions for the machine-mode trap sequencer.
//   - mcause codes for the exceptions and interrupts this core raises
//   - FSM state encoding (also exported on the debug port)
//   - mtvec mode encoding for vectored interrupt dispatch
//   - trap_req_t: the priority encoder's result bundle
package trap_ctrl_pkg;

  // Exception cause codes (mcause[31] == 0)
  localparam logic [3:0] CAUSE_FETCH_MIS = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_BREAK     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MIS  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MIS = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M   = 4'd11;

  // Interrupt cause codes (mcause[31] == 1)
  localparam logic [3:0] CAUSE_IRQ_SW    = 4'd3;
  localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;

  // mtvec[1:0] value selecting vectored interrupt dispatch
  localparam logic [1:0] MTVEC_MODE_VEC  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP_WR  = 2'd1,
    ST_TRAP_JMP = 2'd2,
    ST_MRET_JMP = 2'd3
  } trap_state_t;

  // Winning trap request: is_irq = 1 for interrupt, 0 for exception
  typedef struct packed {
    logic        valid;
    logic        is_irq;
    logic [3:0]  cause;
    logic [31:0] mtval;
  } trap_req_t;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// trap_prio_enc: combinational priority encoder for trap requests.
// Exceptions beat interrupts. Among exceptions the order is
// fetch_mis > illegal > ebreak > ecall > load_mis > store_mis.
// Among interrupts it is external > software > timer. The irq_* inputs
// arrive already masked by mie and mstatus.MIE.
// Ports:
//   instr_valid            - instruction at commit qualifies all requests
//   exc_*                  - raw exception flags
//   irq_ext/irq_sw/irq_timer - enabled, pending interrupts
//   pc, instr, fault_addr  - mtval sources
//   req                    - {valid, is_irq, cause, mtval}
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic        instr_valid,
  input  logic        exc_fetch_mis,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        exc_load_mis,
  input  logic        exc_store_mis,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] fault_addr,
  output trap_req_t   req
);

  always_comb begin
    req = '0;
    if (instr_valid) begin
      req.valid = 1'b1;
      if (exc_fetch_mis) begin
        req.cause = CAUSE_FETCH_MIS;
        req.mtval = fault_addr;
      end else if (exc_illegal) begin
        req.cause = CAUSE_ILLEGAL;
        req.mtval = instr;
      end else if (exc_ebreak) begin
        req.cause = CAUSE_BREAK;
        req.mtval = pc;
      end else if (exc_ecall) begin
        req.cause = CAUSE_ECALL_M;
      end else if (exc_load_mis) begin
        req.cause = CAUSE_LOAD_MIS;
        req.mtval = fault_addr;
      end else if (exc_store_mis) begin
        req.cause = CAUSE_STORE_MIS;
        req.mtval = fault_addr;
      end else if (irq_ext) begin
        req.is_irq = 1'b1;
        req.cause  = CAUSE_IRQ_EXT;
      end else if (irq_sw) begin
        req.is_irq = 1'b1;
        req.cause  = CAUSE_IRQ_SW;
      end else if (irq_timer) begin
        req.is_irq = 1'b1;
        req.cause  = CAUSE_IRQ_TIMER;
      end else begin
        req.valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between commit and the CSR file.
// Detects exceptions / enabled interrupts / mret at commit, writes the
// CSR trap state, flushes the pipeline and redirects fetch.
// Ports:
//   ck_i, rs_i               - clock, synchronous active-high reset
//   instr_valid_i, pc_i, instr_i, exc_*_i, fault_addr_i, mret_i
//                            - commit-point instruction and its flags
//   mstatus_ie_i, mie_*_i, mip_*_i, mtvec_i, epc_i - CSR file state
//   ie_type_o, set_cause_o, trap_cause_o, set_epc_o, epc_o,
//   set_mtval_o, mtval_o, mstatus_ie_clear_o, mstatus_ie_set_o
//                            - CSR hardware update strobes/data
//   flush_o, stall_o         - pipeline control
//   redirect_o, redirect_pc_o - fetch redirect
//   state_o                  - current FSM state, for debug/checkers
// Handshake: detection is a one-cycle event in IDLE; the pipeline is
// stalled (stall_o) for every non-IDLE cycle, so no request can be
// presented until IDLE returns. Requests seen outside IDLE are ignored.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        ck_i,
  input  logic        rs_i,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        exc_fetch_mis_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_ecall_i,
  input  logic        exc_load_mis_i,
  input  logic        exc_store_mis_i,
  input  logic [31:0] fault_addr_i,
  input  logic        mret_i,
  input  logic        mstatus_ie_i,
  input  logic        mie_external_i,
  input  logic        mie_timer_i,
  input  logic        mie_sw_i,
  input  logic        mip_external_i,
  input  logic        mip_timer_i,
  input  logic        mip_software_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] epc_i,
  output logic        ie_type_o,
  output logic        set_cause_o,
  output logic [3:0]  trap_cause_o,
  output logic        set_epc_o,
  output logic [31:0] epc_o,
  output logic        set_mtval_o,
  output logic [31:0] mtval_o,
  output logic        mstatus_ie_clear_o,
  output logic        mstatus_ie_set_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output trap_state_t state_o
);

  trap_state_t state_q, state_d;
  trap_req_t   req;

  logic        ie_type_q;
  logic [3:0]  cause_q;
  logic [31:0] epc_q;
  logic [31:0] mtval_q;

  logic        use_vector;
  logic [31:0] vec_base;

  trap_prio_enc u_prio (
    .instr_valid   (instr_valid_i),
    .exc_fetch_mis (exc_fetch_mis_i),
    .exc_illegal   (exc_illegal_i),
    .exc_ebreak    (exc_ebreak_i),
    .exc_ecall     (exc_ecall_i),
    .exc_load_mis  (exc_load_mis_i),
    .exc_store_mis (exc_store_mis_i),
    .irq_ext       (mstatus_ie_i & mie_external_i & mip_external_i),
    .irq_sw        (mstatus_ie_i & mie_sw_i & mip_software_i),
    .irq_timer     (mstatus_ie_i & mie_timer_i & mip_timer_i),
    .pc            (pc_i),
    .instr         (instr_i),
    .fault_addr    (fault_addr_i),
    .req           (req)
  );

  // mtvec is read live in TRAP_JMP so a just-committed mtvec write counts.
  assign vec_base   = {mtvec_i[31:2], 2'b00};
  assign use_vector = VECTORED_EN && (mtvec_i[1:0] == MTVEC_MODE_VEC) && ie_type_q;

  always_ff @(posedge ck_i) begin
    if (rs_i) begin
      state_q   <= ST_IDLE;
      ie_type_q <= 1'b0;
      cause_q   <= 4'd0;
      epc_q     <= 32'd0;
      mtval_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req.valid) begin
        ie_type_q <= req.is_irq;
        cause_q   <= req.cause;
        epc_q     <= pc_i;
        mtval_q   <= req.mtval;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    ie_type_o          = 1'b0;
    set_cause_o        = 1'b0;
    trap_cause_o       = 4'd0;
    set_epc_o          = 1'b0;
    epc_o              = 32'd0;
    set_mtval_o        = 1'b0;
    mtval_o            = 32'd0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;
    flush_o            = 1'b0;
    redirect_o         = 1'b0;
    redirect_pc_o      = 32'd0;
    case (state_q)
      ST_IDLE: begin
        // A trap request shadows a simultaneous mret.
        if (req.valid) begin
          state_d = ST_TRAP_WR;
          flush_o = ~rs_i;
        end else if (instr_valid_i && mret_i) begin
          state_d = ST_MRET_JMP;
          flush_o = ~rs_i;
        end
      end
      ST_TRAP_WR: begin
        set_cause_o        = 1'b1;
        set_epc_o          = 1'b1;
        set_mtval_o        = 1'b1;
        mstatus_ie_clear_o = 1'b1;
        ie_type_o          = ie_type_q;
        trap_cause_o       = cause_q;
        epc_o              = epc_q;
        mtval_o            = mtval_q;
        state_d            = ST_TRAP_JMP;
      end
      ST_TRAP_JMP: begin
        redirect_o    = 1'b1;
        redirect_pc_o = use_vector ? (vec_base + {26'd0, cause_q, 2'b00}) : vec_base;
        state_d       = ST_IDLE;
      end
      ST_MRET_JMP: begin
        redirect_o       = 1'b1;
        mstatus_ie_set_o = 1'b1;
        redirect_pc_o    = epc_i;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_o = (state_q != ST_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl. Two instances share all inputs: dut
// (vectored dispatch enabled) and dut_nv (vectored dispatch disabled).
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        ck_i = 1'b0;
  logic        rs_i;
  logic        instr_valid_i;
  logic [31:0] pc_i, instr_i, fault_addr_i, mtvec_i, epc_i;
  logic        exc_fetch_mis_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i;
  logic        exc_load_mis_i, exc_store_mis_i, mret_i;
  logic        mstatus_ie_i, mie_external_i, mie_timer_i, mie_sw_i;
  logic        mip_external_i, mip_timer_i, mip_software_i;

  logic        ie_type_o, set_cause_o, set_epc_o, set_mtval_o;
  logic [3:0]  trap_cause_o;
  logic [31:0] epc_o, mtval_o, redirect_pc_o;
  logic        mstatus_ie_clear_o, mstatus_ie_set_o, flush_o, stall_o, redirect_o;
  trap_state_t state_o;

  logic        nv_ie_type, nv_set_cause, nv_set_epc, nv_set_mtval;
  logic [3:0]  nv_trap_cause;
  logic [31:0] nv_epc, nv_mtval, nv_redirect_pc;
  logic        nv_ie_clear, nv_ie_set, nv_flush, nv_stall, nv_redirect;
  trap_state_t nv_state;

  int total = 0;
  int bad   = 0;

  // clock/reset block
  always #5 ck_i = ~ck_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  trap_ctrl #(.VECTORED_EN(1'b1)) dut (
    .ck_i(ck_i), .rs_i(rs_i), .instr_valid_i(instr_valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .exc_fetch_mis_i(exc_fetch_mis_i), .exc_illegal_i(exc_illegal_i), .exc_ebreak_i(exc_ebreak_i),
    .exc_ecall_i(exc_ecall_i), .exc_load_mis_i(exc_load_mis_i), .exc_store_mis_i(exc_store_mis_i),
    .fault_addr_i(fault_addr_i), .mret_i(mret_i), .mstatus_ie_i(mstatus_ie_i),
    .mie_external_i(mie_external_i), .mie_timer_i(mie_timer_i), .mie_sw_i(mie_sw_i),
    .mip_external_i(mip_external_i), .mip_timer_i(mip_timer_i), .mip_software_i(mip_software_i),
    .mtvec_i(mtvec_i), .epc_i(epc_i), .ie_type_o(ie_type_o), .set_cause_o(set_cause_o),
    .trap_cause_o(trap_cause_o), .set_epc_o(set_epc_o), .epc_o(epc_o), .set_mtval_o(set_mtval_o),
    .mtval_o(mtval_o), .mstatus_ie_clear_o(mstatus_ie_clear_o), .mstatus_ie_set_o(mstatus_ie_set_o),
    .flush_o(flush_o), .stall_o(stall_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .state_o(state_o)
  );

  trap_ctrl #(.VECTORED_EN(1'b0)) dut_nv (
    .ck_i(ck_i), .rs_i(rs_i), .instr_valid_i(instr_valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .exc_fetch_mis_i(exc_fetch_mis_i), .exc_illegal_i(exc_illegal_i), .exc_ebreak_i(exc_ebreak_i),
    .exc_ecall_i(exc_ecall_i), .exc_load_mis_i(exc_load_mis_i), .exc_store_mis_i(exc_store_mis_i),
    .fault_addr_i(fault_addr_i), .mret_i(mret_i), .mstatus_ie_i(mstatus_ie_i),
    .mie_external_i(mie_external_i), .mie_timer_i(mie_timer_i), .mie_sw_i(mie_sw_i),
    .mip_external_i(mip_external_i), .mip_timer_i(mip_timer_i), .mip_software_i(mip_software_i),
    .mtvec_i(mtvec_i), .epc_i(epc_i), .ie_type_o(nv_ie_type), .set_cause_o(nv_set_cause),
    .trap_cause_o(nv_trap_cause), .set_epc_o(nv_set_epc), .epc_o(nv_epc), .set_mtval_o(nv_set_mtval),
    .mtval_o(nv_mtval), .mstatus_ie_clear_o(nv_ie_clear), .mstatus_ie_set_o(nv_ie_set),
    .flush_o(nv_flush), .stall_o(nv_stall), .redirect_o(nv_redirect), .redirect_pc_o(nv_redirect_pc),
    .state_o(nv_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge ck_i);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid_i   = 1'b0;
    pc_i            = 32'd0;
    instr_i         = 32'd0;
    fault_addr_i    = 32'd0;
    exc_fetch_mis_i = 1'b0;
    exc_illegal_i   = 1'b0;
    exc_ebreak_i    = 1'b0;
    exc_ecall_i     = 1'b0;
    exc_load_mis_i  = 1'b0;
    exc_store_mis_i = 1'b0;
    mret_i          = 1'b0;
    mstatus_ie_i    = 1'b0;
    mie_external_i  = 1'b0;
    mie_timer_i     = 1'b0;
    mie_sw_i        = 1'b0;
    mip_external_i  = 1'b0;
    mip_timer_i     = 1'b0;
    mip_software_i  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All write strobes and redirect low, as in IDLE
  task automatic check_quiet(input string tag);
    check({tag, ".strobes"},
          {27'd0, set_cause_o, set_epc_o, set_mtval_o, mstatus_ie_clear_o, mstatus_ie_set_o}, 32'd0);
    check({tag, ".redirect"}, {31'd0, redirect_o}, 32'd0);
    check({tag, ".redirect_pc"}, redirect_pc_o, 32'd0);
  endtask

  initial begin
    clear_inputs();
    mtvec_i = 32'h0000_0200;
    epc_i   = 32'd0;
    rs_i    = 1'b1;
    tick();
    tick();
    // reset state
    check("rst.state", {30'd0, state_o}, {30'd0, ST_IDLE});
    check("rst.stall", {31'd0, stall_o}, 32'd0);
    check("rst.flush", {31'd0, flush_o}, 32'd0);
    check_quiet("rst");
    rs_i = 1'b0;
    tick();

    // illegal instruction, direct mtvec
    instr_valid_i = 1'b1; pc_i = 32'h100; instr_i = 32'hFFFF_FFFF; exc_illegal_i = 1'b1;
    #1;
    check("ill.N.flush", {31'd0, flush_o}, 32'd1);
    check("ill.N.stall", {31'd0, stall_o}, 32'd0);
    tick();
    clear_inputs();
    #1;
    check("ill.N1.set_cause", {31'd0, set_cause_o}, 32'd1);
    check("ill.N1.cause", {28'd0, trap_cause_o}, 32'd2);
    check("ill.N1.type", {31'd0, ie_type_o}, 32'd0);
    check("ill.N1.set_epc", {31'd0, set_epc_o}, 32'd1);
    check("ill.N1.epc", epc_o, 32'h100);
    check("ill.N1.set_mtval", {31'd0, set_mtval_o}, 32'd1);
    check("ill.N1.mtval", mtval_o, 32'hFFFF_FFFF);
    check("ill.N1.ie_clear", {31'd0, mstatus_ie_clear_o}, 32'd1);
    check("ill.N1.stall", {31'd0, stall_o}, 32'd1);
    check("ill.N1.flush", {31'd0, flush_o}, 32'd0);
    check("ill.N1.redirect", {31'd0, redirect_o}, 32'd0);
    tick();
    check("ill.N2.redirect", {31'd0, redirect_o}, 32'd1);
    check("ill.N2.pc", redirect_pc_o, 32'h200);
    check("ill.N2.set_cause", {31'd0, set_cause_o}, 32'd0);
    tick();
    check("ill.N3.stall", {31'd0, stall_o}, 32'd0);
    check_quiet("ill.N3");

    // timer interrupt, vectored mtvec (and direct in dut_nv)
    mtvec_i = 32'h301;
    instr_valid_i = 1'b1; pc_i = 32'h40;
    mstatus_ie_i = 1'b1; mie_timer_i = 1'b1; mip_timer_i = 1'b1;
    #1;
    check("tmr.N.flush", {31'd0, flush_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("tmr.N1.cause", {28'd0, trap_cause_o}, 32'd7);
    check("tmr.N1.type", {31'd0, ie_type_o}, 32'd1);
    check("tmr.N1.epc", epc_o, 32'h40);
    check("tmr.N1.mtval", mtval_o, 32'd0);
    check("tmr.N1.set_mtval", {31'd0, set_mtval_o}, 32'd1);
    tick();
    check("tmr.N2.redirect", {31'd0, redirect_o}, 32'd1);
    check("tmr.N2.pc_vec", redirect_pc_o, 32'h31C);
    check("tmr.N2.pc_novec", nv_redirect_pc, 32'h300);
    tick();

    // all three interrupts pending: external wins
    instr_valid_i = 1'b1; pc_i = 32'h80; mstatus_ie_i = 1'b1;
    mie_external_i = 1'b1; mie_timer_i = 1'b1; mie_sw_i = 1'b1;
    mip_external_i = 1'b1; mip_timer_i = 1'b1; mip_software_i = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("irq3.cause", {28'd0, trap_cause_o}, 32'd11);
    check("irq3.type", {31'd0, ie_type_o}, 32'd1);
    tick();
    check("irq3.pc_vec", redirect_pc_o, 32'h32C);
    tick();

    // same but globally disabled: no trap
    instr_valid_i = 1'b1; pc_i = 32'h80; mstatus_ie_i = 1'b0;
    mie_external_i = 1'b1; mie_timer_i = 1'b1; mie_sw_i = 1'b1;
    mip_external_i = 1'b1; mip_timer_i = 1'b1; mip_software_i = 1'b1;
    #1;
    check("irqoff.flush", {31'd0, flush_o}, 32'd0);
    tick();
    check("irqoff.stall", {31'd0, stall_o}, 32'd0);
    check_quiet("irqoff");
    clear_inputs();

    // ecall with external irq: exception wins, direct target
    instr_valid_i = 1'b1; pc_i = 32'h500; exc_ecall_i = 1'b1;
    mstatus_ie_i = 1'b1; mie_external_i = 1'b1; mip_external_i = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("ecall.cause", {28'd0, trap_cause_o}, 32'd11);
    check("ecall.type", {31'd0, ie_type_o}, 32'd0);
    check("ecall.mtval", mtval_o, 32'd0);
    check("ecall.epc", epc_o, 32'h500);
    tick();
    check("ecall.pc", redirect_pc_o, 32'h300);
    tick();

    // mret
    epc_i = 32'h1234;
    instr_valid_i = 1'b1; mret_i = 1'b1;
    #1;
    check("mret.N.flush", {31'd0, flush_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("mret.N1.ie_set", {31'd0, mstatus_ie_set_o}, 32'd1);
    check("mret.N1.ie_clear", {31'd0, mstatus_ie_clear_o}, 32'd0);
    check("mret.N1.redirect", {31'd0, redirect_o}, 32'd1);
    check("mret.N1.pc", redirect_pc_o, 32'h1234);
    check("mret.N1.set_cause", {31'd0, set_cause_o}, 32'd0);
    tick();
    check("mret.N2.stall", {31'd0, stall_o}, 32'd0);
    check_quiet("mret.N2");

    // mret with ebreak, request held through the sequence
    instr_valid_i = 1'b1; pc_i = 32'h600; mret_i = 1'b1; exc_ebreak_i = 1'b1;
    tick();
    pc_i = 32'h700;
    #1;
    check("brk.N1.cause", {28'd0, trap_cause_o}, 32'd3);
    check("brk.N1.mtval", mtval_o, 32'h600);
    check("brk.N1.epc", epc_o, 32'h600);
    check("brk.N1.ie_set", {31'd0, mstatus_ie_set_o}, 32'd0);
    check("brk.N1.flush_ignored", {31'd0, flush_o}, 32'd0);
    tick();
    check("brk.N2.pc", redirect_pc_o, 32'h300);
    check("brk.N2.flush_ignored", {31'd0, flush_o}, 32'd0);
    tick();
    check("brk.N3.accept", {31'd0, flush_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("brk2.epc", epc_o, 32'h700);
    tick();
    tick();

    // reset during TRAP_WR
    mtvec_i = 32'h200;
    instr_valid_i = 1'b1; pc_i = 32'h100; exc_load_mis_i = 1'b1; fault_addr_i = 32'h0000_0123;
    tick();
    clear_inputs();
    #1;
    check("rstwr.pre.cause", {28'd0, trap_cause_o}, 32'd4);
    check("rstwr.pre.mtval", mtval_o, 32'h123);
    rs_i = 1'b1;
    tick();
    rs_i = 1'b0;
    #1;
    check("rstwr.state", {30'd0, state_o}, {30'd0, ST_IDLE});
    check("rstwr.stall", {31'd0, stall_o}, 32'd0);
    check_quiet("rstwr");
    tick();
    check("rstwr.after", {31'd0, redirect_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the EX/commit stage and the CSR file. It detects synchronous exceptions, pending enabled interrupts and `mret`, and drives the CSR file's hardware update strobes (cause, epc, mtval, mstatus IE clear/set). It then flushes the pipeline and redirects fetch to the trap vector or to `mepc`. It is the "ctrl" agent named on the CSR file's trap-update ports.

## Interface
- `VECTORED_EN`, default 1: honour `mtvec[1:0]==2'b01`; when 0, all traps go to the direct base.
- `ck_i` in 1: clock.
- `rs_i` in 1: synchronous reset, active-high.
- `instr_valid_i` in 1: a valid instruction sits at the commit point this cycle.
- `pc_i` in 32: PC of that instruction.
- `instr_i` in 32: instruction word, used as mtval on illegal-instruction traps.
- `exc_fetch_mis_i`, `exc_illegal_i`, `exc_ebreak_i`, `exc_ecall_i`, `exc_load_mis_i`, `exc_store_mis_i` in 1 each: exception flags, qualified by `instr_valid_i`.
- `fault_addr_i` in 32: faulting address for misaligned exceptions.
- `mret_i` in 1: committing instruction is `mret`.
- `mstatus_ie_i`, `mie_external_i`, `mie_timer_i`, `mie_sw_i`, `mip_external_i`, `mip_timer_i`, `mip_software_i` in 1 each: from the CSR file.
- `mtvec_i`, `epc_i` in 32: from the CSR file.
- `ie_type_o` out 1: 1 means interrupt, 0 means exception.
- `set_cause_o` out 1, `trap_cause_o` out 4.
- `set_epc_o` out 1, `epc_o` out 32.
- `set_mtval_o` out 1, `mtval_o` out 32.
- `mstatus_ie_clear_o`, `mstatus_ie_set_o` out 1 each.
- `flush_o` out 1: kill IF/ID/EX contents.
- `stall_o` out 1: hold the pipeline.
- `redirect_o` out 1, `redirect_pc_o` out 32: fetch redirect.

## Operation
- FSM states: IDLE, TRAP_WR, TRAP_JMP, MRET_JMP.
- All outputs reset to 0. The state resets to IDLE. Internal cause/epc/mtval/type registers reset to 0.
- **Trap request** (evaluated in IDLE only):
  - `exc_any = instr_valid_i & |exc_*`.
  - `irq_any = instr_valid_i & mstatus_ie_i & |(mie & mip)`.
- **Priority:** exception beats interrupt beats mret.
- **Exception priority and causes:**
  - fetch_mis: cause 0, mtval = `fault_addr_i`.
  - illegal: cause 2, mtval = `instr_i`.
  - ebreak: cause 3, mtval = `pc_i`.
  - ecall: cause 11, mtval = 0.
  - load_mis: cause 4, mtval = `fault_addr_i`.
  - store_mis: cause 6, mtval = `fault_addr_i`.
- **Interrupt priority:** external (11) > software (3) > timer (7). mtval = 0.
- **IDLE → TRAP_WR** on `exc_any|irq_any`:
  - Latch type, cause, `epc = pc_i`, and mtval.
  - Assert `flush_o` this cycle.
  - For an interrupt, the instruction is not executed and epc points at it.
- **TRAP_WR**, one cycle:
  - Pulse `set_cause_o`, `set_epc_o`, `mstatus_ie_clear_o`.
  - Pulse `set_mtval_o` (also for zero values).
  - Drive `ie_type_o`, `trap_cause_o`, `epc_o`, `mtval_o` from the latches.
  - Next state: TRAP_JMP.
- **TRAP_JMP**, one cycle:
  - Pulse `redirect_o`.
  - `redirect_pc_o = {mtvec_i[31:2],2'b00}`.
  - If `VECTORED_EN`, `mtvec_i[1:0]==01` and type is interrupt, add `{cause,2'b00}` (32-bit add, wrap ignored).
  - Next state: IDLE.
- **IDLE → MRET_JMP** on `instr_valid_i & mret_i` with no trap. Assert `flush_o`.
- **MRET_JMP**, one cycle:
  - Pulse `mstatus_ie_set_o` and `redirect_o`.
  - `redirect_pc_o = epc_i`.
  - Next state: IDLE.
- `stall_o = (state != IDLE)`.
- Requests arriving in non-IDLE states are ignored. The pipeline is flushed/stalled, so none are legal.
- `mret` together with an exception flag: the exception wins and mret is dropped.
- Reset in any state: return to IDLE next edge, all strobes low, no redirect.

## Timing
- Detect at cycle N (flush). CSR write strobes at N+1. Redirect at N+2. IDLE at N+3, and a new trap is accepted at N+3.
- TRAP_JMP reads the `mtvec_i` value current at N+2, so an mtvec write committed before the trapping instruction is visible.
- mret: detect at N, redirect and IE set at N+1, IDLE at N+2.
- Strobes are exactly one cycle wide. `redirect_pc_o` is 0 when `redirect_o` is low.
- Detection is combinational from inputs. All outputs other than `flush_o` are registered or state-decoded.

## Structure
- Shared package/defines header (`defines.v`) holds:
  - cause codes: `CAUSE_FETCH_MIS`=0, `CAUSE_ILLEGAL`=2, `CAUSE_BREAK`=3, `CAUSE_LOAD_MIS`=4, `CAUSE_STORE_MIS`=6, `CAUSE_ECALL_M`=11, `CAUSE_IRQ_SW`=3, `CAUSE_IRQ_TIMER`=7, `CAUSE_IRQ_EXT`=11.
  - FSM state encodings.
  - `MTVEC_MODE_VEC`=2'b01.
- One sub-module, `trap_prio_enc`: combinational priority encoder producing `{valid, type, cause[3:0], mtval[31:0]}` from the exception and interrupt vectors.

## Test plan
- Illegal at `pc_i=0x100`, `instr_i=0xFFFF_FFFF`, `mtvec=0x200`:
  - N+1: set_cause with cause 2, type 0; epc 0x100; mtval 0xFFFF_FFFF; ie_clear.
  - N+2: redirect to 0x200.
- Timer irq (ie=1, mie_timer=1, mip_timer=1) at `pc_i=0x40`, `mtvec=0x301` vectored: cause 7, type 1, epc 0x40, redirect 0x31C. With `VECTORED_EN=0`: redirect 0x300.
- External + timer + software pending simultaneously: cause 11. With `mstatus_ie_i=0`: no trap, stall_o stays 0.
- ecall and an external irq in the same cycle: exception taken, cause 11, type 0, mtval 0.
- mret with `epc_i=0x1234`: N+1 ie_set pulse, redirect 0x1234, stall_o low by N+2.
- `rs_i` asserted during TRAP_WR: the next cycle shows IDLE, no redirect, all strobes 0.
